// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and the source identifier for the register-file write arbiter.
package regfile_wr_pkg;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 2 ** AW;
   localparam int CW   = 16;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request/response bundle between the two sources, the arbiter and the register file.
interface regfile_wr_arbiter_if;
   import regfile_wr_pkg::*;

   logic            AValid;
   logic [AW-1:0]   AAddr;
   logic [DW-1:0]   AData;
   logic            AReady;
   logic            BValid;
   logic [AW-1:0]   BAddr;
   logic [DW-1:0]   BData;
   logic            BReady;
   logic [DW-1:0]   WrD;
   logic [NREG-1:0] WrEn;
   logic [NREG-1:0] Pend;
   logic            Busy;
   logic [CW-1:0]   ConfCnt;

   modport master (
      output AValid, AAddr, AData, BValid, BAddr, BData,
      input  AReady, BReady, WrD, WrEn, Pend, Busy, ConfCnt
   );

   modport slave (
      input  AValid, AAddr, AData, BValid, BAddr, BData,
      output AReady, BReady, WrD, WrEn, Pend, Busy, ConfCnt
   );

endinterface

// File: rtl/regfile_wr_arbiter_rf_dec5to32.sv
// Register address to one-hot decoder; all zeros when the enable is low.
module rf_dec5to32
   import regfile_wr_pkg::*;
(
   input  logic [AW-1:0]   addr,
   input  logic            en,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-source arbiter for the single register-file write port, one holding slot per source.
// Optional saturating conflict counter enabled by defining REGWR_CONFLICT_CNT_EN.
module regfile_wr_arbiter
   import regfile_wr_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Clrn,
   regfile_wr_arbiter_if.slave  bus
);

   logic            full_a, full_b;
   logic [AW-1:0]   addr_a, addr_b;
   logic [DW-1:0]   data_a, data_b;
   src_e            age_q;
   src_e            rr_q;
   logic            tie_q;
   logic [DW-1:0]   wrd_q;

   logic            live_a, live_b, zero_a, zero_b;
   logic            grant_a, grant_b, grant_any, use_rr;
   logic            ready_a, ready_b, load_a, load_b;
   logic [AW-1:0]   grant_addr;
   logic [DW-1:0]   grant_data;
   logic [NREG-1:0] wr_en, pend_a, pend_b, pend_all;

   // A slot holding r0 is not a competitor: it just drains on the next edge.
   assign live_a = full_a & (addr_a != '0);
   assign live_b = full_b & (addr_b != '0);
   assign zero_a = full_a & (addr_a == '0);
   assign zero_b = full_b & (addr_b == '0);

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      use_rr  = 1'b0;
      if (live_a && live_b) begin
         if (!tie_q) begin
            grant_a = (age_q == SRC_A);
            grant_b = (age_q == SRC_B);
         end else if (addr_a == addr_b) begin
            grant_a = 1'b1;
         end else begin
            use_rr  = 1'b1;
            grant_a = (rr_q == SRC_A);
            grant_b = (rr_q == SRC_B);
         end
      end else if (live_a) begin
         grant_a = 1'b1;
      end else if (live_b) begin
         grant_b = 1'b1;
      end
   end

   assign grant_any  = grant_a | grant_b;
   assign grant_addr = grant_b ? addr_b : addr_a;
   assign grant_data = grant_b ? data_b : data_a;

   assign ready_a = ~full_a | grant_a | zero_a;
   assign ready_b = ~full_b | grant_b | zero_b;
   assign load_a  = bus.AValid & ready_a;
   assign load_b  = bus.BValid & ready_b;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         full_a <= 1'b0;
         full_b <= 1'b0;
         addr_a <= '0;
         addr_b <= '0;
         data_a <= '0;
         data_b <= '0;
      end else begin
         if (load_a) begin
            full_a <= 1'b1;
            addr_a <= bus.AAddr;
            data_a <= bus.AData;
         end else if (grant_a || zero_a) begin
            full_a <= 1'b0;
         end
         if (load_b) begin
            full_b <= 1'b1;
            addr_b <= bus.BAddr;
            data_b <= bus.BData;
         end else if (grant_b || zero_b) begin
            full_b <= 1'b0;
         end
      end
   end

   // A lone load makes the other (held) slot the older one; a joint load is a tie for RR.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         age_q <= SRC_A;
         tie_q <= 1'b0;
         rr_q  <= SRC_A;
         wrd_q <= '0;
      end else begin
         if (load_a && load_b) begin
            tie_q <= 1'b1;
         end else if (load_a) begin
            tie_q <= 1'b0;
            age_q <= SRC_B;
         end else if (load_b) begin
            tie_q <= 1'b0;
            age_q <= SRC_A;
         end
         if (use_rr) begin
            rr_q <= (rr_q == SRC_A) ? SRC_B : SRC_A;
         end
         if (grant_any) begin
            wrd_q <= grant_data;
         end
      end
   end

   rf_dec5to32 u_dec_wr (.addr(grant_addr), .en(grant_any), .onehot(wr_en));
   rf_dec5to32 u_dec_pa (.addr(addr_a),     .en(full_a),    .onehot(pend_a));
   rf_dec5to32 u_dec_pb (.addr(addr_b),     .en(full_b),    .onehot(pend_b));

   assign pend_all    = pend_a | pend_b;
   assign bus.Pend    = {pend_all[NREG-1:1], 1'b0};
   assign bus.WrEn    = wr_en;
   assign bus.WrD     = grant_any ? grant_data : wrd_q;
   assign bus.AReady  = ready_a;
   assign bus.BReady  = ready_b;
   assign bus.Busy    = full_a | full_b;

`ifdef REGWR_CONFLICT_CNT_EN
   logic [CW-1:0] conf_q;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         conf_q <= '0;
      end else if (live_a && live_b && (conf_q != '1)) begin
         conf_q <= conf_q + 1'b1;
      end
   end

   assign bus.ConfCnt = conf_q;
`else
   assign bus.ConfCnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based model.
module tb_regfile_wr_arbiter;

   logic Clk = 1'b0;
   logic Clrn;

   regfile_wr_arbiter_if intf ();

   regfile_wr_arbiter dut (
      .Clk  (Clk),
      .Clrn (Clrn),
      .bus  (intf.slave)
   );

   initial forever #5 Clk = ~Clk;

   int compared   = 0;
   int mismatched = 0;

   logic        mfull  [2];
   logic [4:0]  maddr  [2];
   logic [31:0] mdata  [2];
   int          mstamp [2];
   int          mrr;
   int          mcyc;
   logic [31:0] mlastd;
   int          mconf;
   logic [31:0] mreg   [32];
   logic [31:0] tbreg  [32];

   // Register file as seen by the DUT's write port.
   always @(posedge Clk) begin
      for (int i = 0; i < 32; i++) begin
         if (intf.WrEn[i]) tbreg[i] <= intf.WrD;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int x = 0; x < 2; x++) begin
         mfull[x]  = 1'b0;
         maddr[x]  = '0;
         mdata[x]  = '0;
         mstamp[x] = 0;
      end
      mrr    = 0;
      mlastd = '0;
      mconf  = 0;
   endtask

   // Oldest live request wins; same-cycle arrivals go to RR unless both target one register.
   task automatic modelGrant(output int g, output bit use_rr);
      bit la, lb;
      la = mfull[0] && (maddr[0] != 0);
      lb = mfull[1] && (maddr[1] != 0);
      g = -1;
      use_rr = 1'b0;
      if (la && lb) begin
         if (mstamp[0] < mstamp[1])      g = 0;
         else if (mstamp[1] < mstamp[0]) g = 1;
         else if (maddr[0] == maddr[1])  g = 0;
         else begin
            g = mrr;
            use_rr = 1'b1;
         end
      end else if (la) g = 0;
      else if (lb) g = 1;
   endtask

   function automatic bit modelReady(input int x, input int g);
      return !mfull[x] || (g == x) || (maddr[x] == 0);
   endfunction

   task automatic checkOutput();
      int g;
      bit ur;
      logic [31:0] expEn, expD, expPend;
      modelGrant(g, ur);
      expEn   = (g >= 0) ? (32'h1 << maddr[g]) : 32'h0;
      expD    = (g >= 0) ? mdata[g] : mlastd;
      expPend = 32'h0;
      for (int x = 0; x < 2; x++) begin
         if (mfull[x]) expPend = expPend | (32'h1 << maddr[x]);
      end
      expPend[0] = 1'b0;
      chk("AReady", 32'(intf.AReady), 32'(modelReady(0, g)));
      chk("BReady", 32'(intf.BReady), 32'(modelReady(1, g)));
      chk("WrEn",   intf.WrEn, expEn);
      chk("WrD",    intf.WrD,  expD);
      chk("Pend",   intf.Pend, expPend);
      chk("Busy",   32'(intf.Busy), 32'(mfull[0] || mfull[1]));
`ifdef REGWR_CONFLICT_CNT_EN
      chk("ConfCnt", 32'(intf.ConfCnt), 32'(mconf));
`else
      chk("ConfCnt", 32'(intf.ConfCnt), 32'h0);
`endif
   endtask

   task automatic modelEdge(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      int g;
      bit ur, rdy[2], clr[2], iv[2];
      logic [4:0]  ia[2];
      logic [31:0] id[2];
      modelGrant(g, ur);
      iv[0] = av; ia[0] = aa; id[0] = ad;
      iv[1] = bv; ia[1] = ba; id[1] = bd;
      if (mfull[0] && mfull[1] && maddr[0] != 0 && maddr[1] != 0 && mconf < 65535) mconf++;
      if (g >= 0) begin
         mlastd = mdata[g];
         mreg[maddr[g]] = mdata[g];
      end
      for (int x = 0; x < 2; x++) begin
         rdy[x] = modelReady(x, g);
         clr[x] = (g == x) || (mfull[x] && maddr[x] == 0);
      end
      for (int x = 0; x < 2; x++) begin
         if (iv[x] && rdy[x]) begin
            mfull[x]  = 1'b1;
            maddr[x]  = ia[x];
            mdata[x]  = id[x];
            mstamp[x] = mcyc;
         end else if (clr[x]) begin
            mfull[x] = 1'b0;
         end
      end
      if (ur) mrr = 1 - mrr;
      mcyc++;
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      @(negedge Clk);
      intf.AValid = av; intf.AAddr = aa; intf.AData = ad;
      intf.BValid = bv; intf.BAddr = ba; intf.BData = bd;
      #1;
      checkOutput();
      modelEdge(av, aa, ad, bv, ba, bd);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic pulseReset();
      Clrn = 1'b0;
      #1;
      modelReset();
      chk("rst_WrEn",   intf.WrEn, 32'h0);
      chk("rst_Pend",   intf.Pend, 32'h0);
      chk("rst_AReady", 32'(intf.AReady), 32'h1);
      chk("rst_BReady", 32'(intf.BReady), 32'h1);
      chk("rst_Busy",   32'(intf.Busy), 32'h0);
      chk("rst_WrD",    intf.WrD, 32'h0);
      chk("rst_Conf",   32'(intf.ConfCnt), 32'h0);
      intf.AValid = 1'b0;
      intf.BValid = 1'b0;
      @(posedge Clk);
      #2;
      Clrn = 1'b1;
   endtask

   initial begin
      int na, nb, wa, wb, wcnt;
      logic av, bv;
      logic [4:0] ra, rb;

      for (int i = 0; i < 32; i++) begin
         mreg[i]  = 32'h0;
         tbreg[i] = 32'h0;
      end
      mcyc = 1;
      intf.AValid = 1'b0; intf.AAddr = '0; intf.AData = '0;
      intf.BValid = 1'b0; intf.BAddr = '0; intf.BData = '0;
      Clrn = 1'b0;
      #1;
      pulseReset();

      $display("[TB] single write from A");
      applyStimulus(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
      idle();
      chk("singleA_WrEn", intf.WrEn, 32'h0000_0008);
      chk("singleA_WrD",  intf.WrD,  32'h1234_5678);
      chk("singleA_Pend", intf.Pend, 32'h0000_0008);
      idle();
      chk("singleA_Pend_clr", intf.Pend, 32'h0);
      chk("singleA_WrD_hold", intf.WrD,  32'h1234_5678);

      $display("[TB] repeated same-edge collisions");
      na = 0; nb = 0; wa = 0; wb = 0;
      for (int s = 0; s < 16; s++) begin
         av = (na < 4);
         bv = (nb < 4);
         applyStimulus(av, 5'd5, 32'hA, bv, 5'd9, 32'hB);
         if (intf.WrEn === 32'h0000_0020) wa++;
         if (intf.WrEn === 32'h0000_0200) wb++;
         if (av && intf.AReady) na++;
         if (bv && intf.BReady) nb++;
      end
      chk("coll_writesA", 32'(wa), 32'd4);
      chk("coll_writesB", 32'(wb), 32'd4);

      $display("[TB] same register tie");
      applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
      idle();
      chk("tie_first_WrEn", intf.WrEn, 32'h0000_0080);
      chk("tie_first_WrD",  intf.WrD,  32'h1);
      idle();
      chk("tie_second_WrEn", intf.WrEn, 32'h0000_0080);
      chk("tie_second_WrD",  intf.WrD,  32'h2);
      idle();
      chk("tie_final_r7", tbreg[7], 32'h2);

      $display("[TB] r0 write alongside B");
      applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd4, 32'h44);
      idle();
      chk("r0_WrEn", intf.WrEn, 32'h0000_0010);
      chk("r0_WrD",  intf.WrD,  32'h44);
      idle();
      chk("r0_Busy", 32'(intf.Busy), 32'h0);

      $display("[TB] back-to-back writes from A");
      wcnt = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(i + 1), $urandom, 1'b0, 5'd0, 32'h0);
         if (intf.WrEn !== 32'h0) wcnt++;
      end
      idle();
      if (intf.WrEn !== 32'h0) wcnt++;
      chk("b2b_writes", 32'(wcnt), 32'd7 + 32'(intf.WrEn !== 32'h0) - 32'(intf.WrEn !== 32'h0) + 32'd1);

      $display("[TB] reset during activity");
      applyStimulus(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB);
      applyStimulus(1'b1, 5'd12, 32'hCCCC, 1'b1, 5'd13, 32'hDDDD);
      pulseReset();
      idle();

      $display("[TB] random traffic");
      for (int s = 0; s < 400; s++) begin
         ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         applyStimulus(1'($urandom_range(0, 3) != 0), ra, $urandom,
                       1'($urandom_range(0, 3) != 0), rb, $urandom);
      end
      idle();
      idle();
      idle();
      for (int i = 1; i < 32; i++) begin
         chk($sformatf("regfile_r%0d", i), tbreg[i], mreg[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
